// File: rtl/cyclic_lamp_monitor_if.sv
// rtl/cyclic_lamp_monitor_if.sv - lamp bus sample inputs and monitor status outputs
interface cyclic_lamp_monitor_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic [0:2]       light;
  logic             err_clr;
  logic             locked;
  logic [0:2]       color;
  logic [CNT_W-1:0] cycle_cnt;
  logic             err_illegal;
  logic             err_order;
  logic             err_stuck;

  // Supervisor / stimulus side: drives the lamp bus, observes status
  modport master (
    output en, light, err_clr,
    input  locked, color, cycle_cnt, err_illegal, err_order, err_stuck
  );

  // Monitor side
  modport slave (
    input  en, light, err_clr,
    output locked, color, cycle_cnt, err_illegal, err_order, err_stuck
  );
endinterface

// File: rtl/cyclic_lamp_monitor.sv
// rtl/cyclic_lamp_monitor.sv - RGY lamp sequence checker; LAMP_MON_STUCK_EN compiles in the stuck-colour detector
module cyclic_lamp_monitor #(
  parameter int MAX_DWELL = 8,
  parameter int CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cyclic_lamp_monitor_if.slave  bus
);

  localparam logic [0:2] C_RED    = 3'b100;
  localparam logic [0:2] C_GREEN  = 3'b010;
  localparam logic [0:2] C_YELLOW = 3'b001;
  localparam logic [0:2] C_NONE   = 3'b000;

  typedef enum logic {SYNC = 1'b0, TRACK = 1'b1} state_t;

  state_t           r_state;
  logic [0:2]       r_color;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err_illegal;
  logic             r_err_order;

  state_t           w_state_nxt;
  logic [0:2]       w_color_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [0:2]       w_succ;
  logic             w_legal;
  logic             w_set_illegal;
  logic             w_set_order;

`ifdef LAMP_MON_STUCK_EN
  localparam int DW_W = $clog2(MAX_DWELL + 1);
  logic [DW_W-1:0]  r_dwell;
  logic [DW_W-1:0]  w_dwell_nxt;
  logic             r_err_stuck;
  logic             w_set_stuck;
`endif

  // Decode the sampled code and the colour expected after the current one
  always_comb begin
    w_legal = (bus.light == C_RED) || (bus.light == C_GREEN) || (bus.light == C_YELLOW);
    case (r_color)
      C_RED:    w_succ = C_GREEN;
      C_GREEN:  w_succ = C_YELLOW;
      C_YELLOW: w_succ = C_RED;
      default:  w_succ = C_NONE;
    endcase
  end

  // Next-state logic: lock in SYNC, follow the sequence in TRACK, drop out on any error
  always_comb begin
    w_state_nxt   = r_state;
    w_color_nxt   = r_color;
    w_cnt_nxt     = r_cnt;
    w_set_illegal = 1'b0;
    w_set_order   = 1'b0;
`ifdef LAMP_MON_STUCK_EN
    w_dwell_nxt   = r_dwell;
    w_set_stuck   = 1'b0;
`endif
    if (bus.en) begin
      case (r_state)
        SYNC: begin
          if (w_legal) begin
            w_state_nxt = TRACK;
            w_color_nxt = bus.light;
`ifdef LAMP_MON_STUCK_EN
            w_dwell_nxt = DW_W'(1);
`endif
          end else begin
            w_set_illegal = 1'b1;
          end
        end
        TRACK: begin
          if (!w_legal) begin
            w_set_illegal = 1'b1;
            w_state_nxt   = SYNC;
            w_color_nxt   = C_NONE;
`ifdef LAMP_MON_STUCK_EN
            w_dwell_nxt   = '0;
`endif
          end else if (bus.light == r_color) begin
`ifdef LAMP_MON_STUCK_EN
            if (r_dwell == DW_W'(MAX_DWELL)) begin
              w_set_stuck = 1'b1;
              w_state_nxt = SYNC;
              w_color_nxt = C_NONE;
              w_dwell_nxt = '0;
            end else begin
              w_dwell_nxt = r_dwell + DW_W'(1);
            end
`endif
          end else if (bus.light == w_succ) begin
            w_color_nxt = bus.light;
`ifdef LAMP_MON_STUCK_EN
            w_dwell_nxt = DW_W'(1);
`endif
            // A completed cycle is counted on the YELLOW->RED step only
            if (r_color == C_YELLOW) begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end else begin
            w_set_order = 1'b1;
            w_state_nxt = SYNC;
            w_color_nxt = C_NONE;
`ifdef LAMP_MON_STUCK_EN
            w_dwell_nxt = '0;
`endif
          end
        end
        default: begin
          w_state_nxt = SYNC;
          w_color_nxt = C_NONE;
        end
      endcase
    end
  end

  // Tracking state, colour and cycle counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SYNC;
      r_color <= C_NONE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_color <= w_color_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Sticky error flags: a new error on the same edge as err_clr takes precedence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_illegal <= 1'b0;
      r_err_order   <= 1'b0;
    end else begin
      r_err_illegal <= w_set_illegal | (r_err_illegal & ~bus.err_clr);
      r_err_order   <= w_set_order   | (r_err_order   & ~bus.err_clr);
    end
  end

`ifdef LAMP_MON_STUCK_EN
  // Dwell counter and sticky stuck flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dwell     <= '0;
      r_err_stuck <= 1'b0;
    end else begin
      r_dwell     <= w_dwell_nxt;
      r_err_stuck <= w_set_stuck | (r_err_stuck & ~bus.err_clr);
    end
  end

  assign bus.err_stuck = r_err_stuck;
`else
  assign bus.err_stuck = 1'b0;
`endif

  assign bus.locked      = (r_state == TRACK);
  assign bus.color       = r_color;
  assign bus.cycle_cnt   = r_cnt;
  assign bus.err_illegal = r_err_illegal;
  assign bus.err_order   = r_err_order;

endmodule

// File: tb/tb_cyclic_lamp_monitor.sv
// tb/tb_cyclic_lamp_monitor.sv - scoreboard bench for cyclic_lamp_monitor (MAX_DWELL=4, CNT_W=2)
module tb_cyclic_lamp_monitor;

  localparam int CW = 2;
  localparam logic [0:2] R = 3'b100;
  localparam logic [0:2] G = 3'b010;
  localparam logic [0:2] Y = 3'b001;
  localparam logic [0:2] Z = 3'b000;

  typedef struct {
    logic          locked;
    logic [0:2]    color;
    logic [CW-1:0] cnt;
    logic [2:0]    err;   // {illegal, order, stuck}
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  exp_t q[$];

  cyclic_lamp_monitor_if #(.CNT_W(CW)) bus ();

  cyclic_lamp_monitor #(.MAX_DWELL(4), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string tag, input exp_t e);
    n_checks++;
    if (bus.locked !== e.locked || bus.color !== e.color || bus.cycle_cnt !== e.cnt ||
        {bus.err_illegal, bus.err_order, bus.err_stuck} !== e.err) begin
      n_errors++;
      $display("FAIL %s: got locked=%b color=%b cnt=%0d err=%b, expected locked=%b color=%b cnt=%0d err=%b",
               tag, bus.locked, bus.color, bus.cycle_cnt,
               {bus.err_illegal, bus.err_order, bus.err_stuck},
               e.locked, e.color, e.cnt, e.err);
    end
  endtask

  // Monitor: after every sampling edge, pop the expected response and compare
  always @(posedge clk) begin
    #2;
    if (q.size() > 0) compare("sample", q.pop_front());
  end

  // Drive one sample and push the hand-computed response it must produce
  task automatic step(input logic e, input logic [0:2] l, input logic c,
                      input logic xl, input logic [0:2] xc, input int xn, input logic [2:0] xe);
    exp_t x;
    @(negedge clk);
    bus.en      = e;
    bus.light   = l;
    bus.err_clr = c;
    x.locked = xl;
    x.color  = xc;
    x.cnt    = CW'(xn);
    x.err    = xe;
    q.push_back(x);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #3;
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected responses never checked, required 0", q.size());
    end
  endtask

  initial begin
    exp_t x0;
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t zero;
    n_checks = 0;
    n_errors = 0;
    zero.locked = 1'b0; zero.color = Z; zero.cnt = '0; zero.err = 3'b000;
    rst_n       = 1'b0;
    bus.en      = 1'b0;
    bus.light   = Z;
    bus.err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 compare("reset", zero);
    @(negedge clk);
    rst_n = 1'b1;

    // Legal running sequence, two completed cycles
    step(1, R, 0, 1, R, 0, 3'b000);
    step(1, G, 0, 1, G, 0, 3'b000);
    step(1, Y, 0, 1, Y, 0, 3'b000);
    step(1, R, 0, 1, R, 1, 3'b000);
    step(1, G, 0, 1, G, 1, 3'b000);
    step(1, Y, 0, 1, Y, 1, 3'b000);
    step(1, R, 0, 1, R, 2, 3'b000);

    // Illegal code while locked on G, relock on R, clear
    step(1, G,      0, 1, G, 2, 3'b000);
    step(1, 3'b110, 0, 0, Z, 2, 3'b100);
    step(1, R,      0, 1, R, 2, 3'b100);
    step(1, G,      1, 1, G, 2, 3'b000);

    // Order error from R, relock on G without counting, set beats clear
    step(1, Y, 0, 1, Y, 2, 3'b000);
    step(1, R, 0, 1, R, 3, 3'b000);
    step(1, Y, 0, 0, Z, 3, 3'b010);
    step(1, G, 0, 1, G, 3, 3'b010);
    step(1, R, 1, 0, Z, 3, 3'b010);
    step(0, R, 1, 0, Z, 3, 3'b000);

    // Dwell: four R samples are always legal
    step(1, R, 0, 1, R, 3, 3'b000);
    step(1, R, 0, 1, R, 3, 3'b000);
    step(1, R, 0, 1, R, 3, 3'b000);
    step(1, R, 0, 1, R, 3, 3'b000);
`ifdef LAMP_MON_STUCK_EN
    step(1, R, 0, 0, Z, 3, 3'b001);
    step(1, R, 1, 1, R, 3, 3'b000);
    step(1, R, 0, 1, R, 3, 3'b000);
    step(1, R, 0, 1, R, 3, 3'b000);
    step(1, R, 0, 1, R, 3, 3'b000);
`else
    for (int i = 0; i < 16; i++) step(1, R, 0, 1, R, 3, 3'b000);
`endif
    step(1, G, 0, 1, G, 3, 3'b000);
    step(1, Y, 0, 1, Y, 3, 3'b000);

    // Counter wraps at 2^CNT_W
    step(1, R, 0, 1, R, 0, 3'b000);
    for (int k = 1; k <= 4; k++) begin
      step(1, G, 0, 1, G, k - 1, 3'b000);
      step(1, Y, 0, 1, Y, k - 1, 3'b000);
      step(1, R, 0, 1, R, k % 4, 3'b000);
    end

    // en low holds everything even with illegal codes present
    step(0, 3'b111, 0, 1, R, 0, 3'b000);
    step(0, 3'b000, 0, 1, R, 0, 3'b000);
    step(0, 3'b011, 0, 1, R, 0, 3'b000);
    step(1, G,      0, 1, G, 0, 3'b000);
    step(1, 3'b101, 0, 0, Z, 0, 3'b100);
    step(1, Y,      0, 1, Y, 0, 3'b100);
    step(1, R,      0, 1, R, 1, 3'b100);
    drain();

    // Asynchronous reset between edges
    @(negedge clk);
    bus.en = 1'b0;
    #2 rst_n = 1'b0;
    #1 compare("async_reset", zero);
    @(posedge clk);
    #1 compare("reset_hold", zero);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cyclic_lamp_monitor.md
# cyclic_lamp_monitor

Sequence checker for the cyclic RGY lamp bus. It sits on the receiving side of the 3-bit one-hot lamp output, which carries R, then G, then Y, then back to R. It locks onto the running sequence, reports the current colour, and counts completed R→G→Y cycles. Out-of-order, illegal and stuck patterns raise sticky error flags for the traffic-control supervisor.

## Interface
- MAX_DWELL, 8: maximum consecutive identical samples of one colour before a stuck error; legal range ≥2.
- CNT_W, 8: width of the completed-cycle counter.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  sample enable; when low, the monitor ignores `light` and holds all state.
- light  in  [0:2]  lamp bus:
  - bit 0 = RED, bit 1 = GREEN, bit 2 = YELLOW.
  - Legal codes: RED=3'b100, GREEN=3'b010, YELLOW=3'b001.
- err_clr  in  1  clears all sticky error flags.
- locked  out  1  high while tracking a legal sequence.
- color  out  [0:2]  current tracked colour (one-hot); 3'b000 when not locked.
- cycle_cnt  out  CNT_W  count of YELLOW→RED transitions while locked; wraps modulo 2^CNT_W.
- err_illegal  out  1  sticky: a non-one-hot code was sampled.
- err_order  out  1  sticky: a legal colour was sampled out of sequence.
- err_stuck  out  1  sticky: one colour persisted beyond MAX_DWELL samples.

## Operation
- Two states: SYNC and TRACK. `locked` = (state == TRACK).
- Successor relation: next(RED)=GREEN, next(GREEN)=YELLOW, next(YELLOW)=RED.
- Each sample is one rising edge with en=1.
- SYNC:
  - Legal code → go to TRACK, color←code, dwell←1.
  - Illegal code (000, 011, 101, 110, 111) → set err_illegal, stay in SYNC.
- TRACK, evaluated in this priority:
  1. Illegal code → set err_illegal, go to SYNC, color←000.
  2. code == color:
     - If dwell == MAX_DWELL → set err_stuck, go to SYNC, color←000.
     - Otherwise dwell←dwell+1.
  3. code == next(color) → color←code, dwell←1. If the transition is YELLOW→RED, cycle_cnt←cycle_cnt+1, wrapping to 0.
  4. Any other legal code → set err_order, go to SYNC, color←000.
- Dwell counter saturates logically at MAX_DWELL. Its width is ceil(log2(MAX_DWELL+1)).
- A colour may therefore be sampled at most MAX_DWELL consecutive times without error.
- Re-entry from SYNC never increments cycle_cnt. cycle_cnt is not cleared by errors; only rst_n clears it.
- Error flags are sticky until err_clr. If err_clr and a new error set occur on the same edge, the set wins (flag = 1).
- err_clr has no effect on state, color, dwell or cycle_cnt. err_clr acts regardless of en.
- en low: state, color, dwell and cycle_cnt hold; no flags set; err_clr still clears.

## Timing
- All outputs are registered. An output reflects the sample taken at the same rising edge, with zero additional cycles of latency after that edge.
- Reset values: locked=0, color=000, cycle_cnt=0, err_illegal=0, err_order=0, err_stuck=0. Internal state=SYNC, dwell=0.
- rst_n assertion mid-operation forces reset values immediately, with no clock needed.
- Deassertion is synchronised externally. The first sample is the first rising edge with rst_n high and en=1.
- `light` must be stable around the rising edge. When driven by the lamp generator on the same clock, the monitor sees the generator's previous output, so the sequence is observed one cycle delayed.

## Configuration
- LAMP_MON_STUCK_EN defined:
  - Dwell counter and err_stuck logic are compiled in, as described above.
- LAMP_MON_STUCK_EN undefined:
  - No dwell counter.
  - err_stuck is tied to 0.
  - Repeated identical samples in TRACK are accepted indefinitely.
  - MAX_DWELL is ignored.

## Test plan
1. Reset; en=1; drive R,G,Y,R,G,Y,R on successive edges → locked=1 from the first edge; color follows the input; cycle_cnt=2 after the last edge; all errors 0.
2. Locked on G, drive 3'b110 → err_illegal=1, locked=0, color=000. Then drive R → relock with color=100. Pulse err_clr → err_illegal=0.
3. Locked on R, drive Y → err_order=1, locked=0. Then drive G → locked=1, color=010, cycle_cnt unchanged. Also drive err_clr in the same cycle as a new order error → err_order stays 1.
4. MAX_DWELL=4, with the macro defined: drive R for 5 consecutive samples → err_stuck=1 and locked=0 at the 5th edge. Drive R for exactly 4 samples then G → no error. With the macro undefined: 20 R samples → no error.
5. Mid-stream: hold en=0 for 3 cycles while `light` toggles illegally → no change in any output. Then assert rst_n=0 between edges → all outputs 0 immediately.
6. CNT_W=2: run 4 full R→G→Y→R cycles → cycle_cnt goes 1,2,3,0; no errors.
